alu_mdu: RTL and testbench

Parametrised successor to the single-cycle ALU for the MIPS datapath. It adds registered results, a start/done handshake, and an iterative multiply/divide unit with architectural HI/LO registers. The block sits in the EX stage. The pipeline control stalls on `Busy` while a MULT/DIV is in flight.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/mdu_iter.sv | 121 ++++++++++++
 rtl/alu_mdu.sv | 103 ++++++++++
 tb/tb_alu_mdu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and MDU state encoding for alu_mdu
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_MULT  = 4'b1011;
  localparam logic [3:0] ALU_MULTU = 4'b1100;
  localparam logic [3:0] ALU_DIV   = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_PASS  = 4'b1111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiply / restoring divide on magnitudes
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_mul,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb, a_q;
  logic             mul_q, neg_q, neg_r, dz_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum, shifted, diff;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc_lo starts as multiplier / dividend and is consumed one bit per iteration
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    hi_nxt  = acc_hi;
    lo_nxt  = acc_lo;
    if (mul_q) begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], acc_lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_nxt = diff[WIDTH-1:0];
      lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = shifted[WIDTH-1:0];
      lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start) state_nxt = MDU_RUN;
      MDU_RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = MDU_FIX;
      MDU_FIX:  state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MDU_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      a_q    <= '0;
      mul_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == MDU_IDLE && start) begin
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= a_mag;
        opb    <= b_mag;
        a_q    <= a;
        mul_q  <= is_mul;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        dz_q   <= ~is_mul & (b == '0);
      end else if (state == MDU_RUN) begin
        cnt    <= cnt + 1'b1;
        acc_hi <= hi_nxt;
        acc_lo <= lo_nxt;
      end
    end
  end

  // sign fix-up; a zero divisor overrides whatever the iterations left behind
  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    if (mul_q) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else if (dz_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? -acc_hi : acc_hi;
      res_lo = neg_q ? -acc_lo : acc_lo;
    end
  end

  assign res_dz    = dz_q;
  assign res_valid = (state == MDU_FIX);
  assign busy      = (state != MDU_IDLE);

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - registered EX-stage ALU with iterative multiply/divide and HI/LO
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0]   sum, dif, alu_res, res_hi, res_lo;
  logic [SHAMT_W-1:0] shamt;
  logic               alu_ovf, is_mdu, alu_go, mdu_go, res_valid, res_dz;

  assign sum    = A + B;
  assign dif    = A - B;
  assign shamt  = B[SHAMT_W-1:0];
  assign is_mdu = (Op == ALU_MULT) | (Op == ALU_MULTU) | (Op == ALU_DIV) | (Op == ALU_DIVU);
  assign alu_go = Start & ~Busy & ~is_mdu;
  assign mdu_go = Start & ~Busy & is_mdu;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (Op)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = dif;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND:  alu_res = A & B;
      ALU_OR:   alu_res = A | B;
      ALU_XOR:  alu_res = A ^ B;
      ALU_NOR:  alu_res = ~(A | B);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, A < B};
      ALU_SLL:  alu_res = A << shamt;
      ALU_SRL:  alu_res = A >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
      ALU_PASS: alu_res = A;
      default:  alu_res = '0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .start     (mdu_go),
    .is_mul    ((Op == ALU_MULT) || (Op == ALU_MULTU)),
    .is_signed ((Op == ALU_MULT) || (Op == ALU_DIV)),
    .a         (A),
    .b         (B),
    .busy      (Busy),
    .res_valid (res_valid),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_dz    (res_dz)
  );

  // alu_go and res_valid never coincide: Busy is still high during FIX
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Out      <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      DivZero  <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= alu_go | res_valid;
      if (alu_go) begin
        Out      <= alu_res;
        Zero     <= (alu_res == '0);
        Overflow <= alu_ovf;
      end else if (res_valid) begin
        Out      <= res_lo;
        Zero     <= (res_lo == '0);
        Overflow <= 1'b0;
        Hi       <= res_hi;
        Lo       <= res_lo;
        DivZero  <= res_dz;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu with a behavioural reference
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0]   Op = 4'h0;
  logic [W-1:0] Out, Hi, Lo;
  logic         Zero, Overflow, DivZero, Busy, Done;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .A(A), .B(B), .Op(Op),
    .Out(Out), .Zero(Zero), .Overflow(Overflow), .DivZero(DivZero),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu_model(input logic [3:0] op, input logic [W-1:0] a, b,
                                    output logic [W-1:0] r, output logic ovf);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0;
    r = '0;
    case (op)
      ALU_ADD:  begin s = sa + sb; r = s[W-1:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      ALU_SUB:  begin s = sa - sb; r = s[W-1:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = (sa < sb) ? 1 : 0;
      ALU_SLTU: r = (a < b) ? 1 : 0;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      default:  r = a;
    endcase
  endfunction

  function automatic void mdu_model(input logic [3:0] op, input logic [W-1:0] a, b,
                                    output logic [W-1:0] hi, lo, output logic dz);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op == ALU_MULT) begin
      p = sa * sb; hi = p[63:32]; lo = p[31:0];
    end else if (op == ALU_MULTU) begin
      up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0];
    end else if (b == '0) begin
      hi = a; lo = '1; dz = 1'b1;
    end else if (op == ALU_DIV) begin
      q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
    end else begin
      lo = a / b; hi = a % b;
    end
  endfunction

  // reference: results apply WIDTH+1 edges after an accepted MDU start
  logic [W-1:0] m_out = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic m_zero = 1'b1, m_ovf = 1'b0, m_dz = 1'b0, m_busy = 1'b0, m_done = 1'b0, p_dz = 1'b0;
  int m_cnt = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_out = '0; m_zero = 1'b1; m_ovf = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
          m_out = p_lo; m_zero = (p_lo == '0); m_ovf = 1'b0; m_done = 1'b1;
        end
      end else if (Start) begin
        if (Op >= ALU_MULT && Op <= ALU_DIVU) begin
          mdu_model(Op, A, B, p_hi, p_lo, p_dz);
          m_cnt = W + 1;
        end else begin
          alu_model(Op, A, B, m_out, m_ovf);
          m_zero = (m_out == '0);
          m_done = 1'b1;
        end
      end
      m_busy = (m_cnt > 0);
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("out", Out, m_out);
      chk("zero", W'(Zero), W'(m_zero));
      chk("overflow", W'(Overflow), W'(m_ovf));
      chk("divzero", W'(DivZero), W'(m_dz));
      chk("hi", Hi, m_hi);
      chk("lo", Lo, m_lo);
      chk("busy", W'(Busy), W'(m_busy));
      chk("done", W'(Done), W'(m_done));
    end
  end

  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    while (!Done && lat < 60) begin
      if (Busy) busy_cyc++;
      @(posedge Clk); #1;
      lat++;
    end
    chk("done_seen", W'(Done), 32'd1);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, b,
                        output int lat, output int busy_cyc);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(lat, busy_cyc);
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, r;
    logic         o;
  } alu_vec_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } mdu_vec_t;

  alu_vec_t av[13];
  mdu_vec_t mv[7];

  initial begin
    int lat, bc, seen;
    av[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    av[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    av[2]  = '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    av[3]  = '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    av[4]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0};
    av[5]  = '{ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0};
    av[6]  = '{ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    av[7]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    av[8]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    av[9]  = '{ALU_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 1'b0};
    av[10] = '{ALU_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};
    av[11] = '{ALU_PASS, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0};
    av[12] = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};

    mv[0] = '{ALU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    mv[1] = '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    mv[2] = '{ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    mv[3] = '{ALU_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    mv[4] = '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    mv[5] = '{ALU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    mv[6] = '{ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out", Out, 32'h0);
    chk("rst_zero", W'(Zero), 32'd1);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    chk("rst_busy", W'(Busy), 32'd0);
    chk("rst_done", W'(Done), 32'd0);
    Reset_n = 1'b1;
    chk_en = 1;

    foreach (av[i]) begin
      run_op(av[i].op, av[i].a, av[i].b, lat, bc);
      chk($sformatf("alu%0d_out", i), Out, av[i].r);
      chk($sformatf("alu%0d_ovf", i), W'(Overflow), W'(av[i].o));
      chk($sformatf("alu%0d_zero", i), W'(Zero), W'(av[i].r == 32'h0));
      chk($sformatf("alu%0d_lat", i), W'(lat), 32'd0);
    end

    foreach (mv[i]) begin
      run_op(mv[i].op, mv[i].a, mv[i].b, lat, bc);
      chk($sformatf("mdu%0d_hi", i), Hi, mv[i].hi);
      chk($sformatf("mdu%0d_lo", i), Lo, mv[i].lo);
      chk($sformatf("mdu%0d_out", i), Out, mv[i].lo);
      chk($sformatf("mdu%0d_dz", i), W'(DivZero), W'(mv[i].dz));
      chk($sformatf("mdu%0d_busy_cycles", i), W'(bc), 32'd33);
      chk($sformatf("mdu%0d_lat", i), W'(lat), 32'd33);
    end

    Start = 1'b1; Op = ALU_MULT; A = 32'hFFFFFFFD; B = 32'h7;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    Start = 1'b1; Op = ALU_ADD; A = 32'h1; B = 32'h1;
    @(posedge Clk); #1;
    Start = 1'b0; Op = ALU_PASS; A = 32'h0; B = 32'h0;
    wait_done(lat, bc);
    chk("ign_hi", Hi, 32'hFFFFFFFF);
    chk("ign_lo", Lo, 32'hFFFFFFEB);
    chk("ign_out", Out, 32'hFFFFFFEB);
    @(posedge Clk); #1;
    chk("ign_no_done", W'(Done), 32'd0);

    Start = 1'b1; Op = ALU_DIV; A = 32'd100; B = 32'd7;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) begin @(posedge Clk); #1; end
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out", Out, 32'h0);
    chk("mid_rst_zero", W'(Zero), 32'd1);
    chk("mid_rst_hi", Hi, 32'h0);
    chk("mid_rst_lo", Lo, 32'h0);
    chk("mid_rst_busy", W'(Busy), 32'd0);
    chk("mid_rst_ovf_dz", W'({Overflow, DivZero}), 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen++;
    end
    chk("mid_rst_no_done", W'(seen), 32'd0);

    run_op(ALU_DIV, 32'hFFFFFF9C, 32'd7, lat, bc);
    chk("post_rst_lo", Lo, 32'hFFFFFFF2);
    chk("post_rst_hi", Hi, 32'hFFFFFFFE);
    chk("post_rst_lat", W'(lat), 32'd33);

    @(posedge Clk); #1;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
